mci_axi_mgr: RTL and testbench
==============================

// Module: mci_axi_mgr
// PURPOSE
//  Single-outstanding AXI4 manager for MCI. Converts simplex internal requests (dv/hold handshake,
//  same fields as the MCI AXI subordinate path) into single-beat AXI reads/writes on an
//  outbound AXI port. Returns read data and error status to the requester.
//  Sits between MCI internal initiators and the SoC fabric.
// PARAMETERS
//  AXI_ADDR_WIDTH  32  address width
//  AXI_DATA_WIDTH  32  data width; AxSIZE = log2(AXI_DATA_WIDTH/8)
//  AXI_USER_WIDTH  32  AxUSER width
//  AXI_ID_WIDTH    8   AxID width
//  TIMEOUT_CYCLES  1024  response watchdog limit (used only with MCI_AXI_MGR_TIMEOUT_EN)
// PORTS
//  clk        in   1    clock
//  rst        in   1    asynchronous reset, active-high
//  req_dv     in   1    request valid; held high until req_hold low
//  req_write  in   1    1=write, 0=read
//  req_addr   in   AW   byte address
//  req_wdata  in   DW   write data
//  req_wstrb  in   DW/8 write strobes
//  req_user   in   UW   driven onto AWUSER/ARUSER
//  req_id     in   IW   driven onto AWID/ARID
//  req_hold   out  1    stall: request not yet complete
//  resp_rdata out  DW   read data, valid with req_dv & !req_hold on reads
//  resp_error out  1    error, valid with req_dv & !req_hold
//  m_axi_aw*/w*/b*/ar*/r*  AXI4 manager channels (valid/ready, addr, id, user, len, size, burst,
//             data, strb, last, resp)
// BEHAVIOUR
//  Reset: state=IDLE; all AXI valid outputs 0, BREADY/RREADY 0; resp_rdata 0; resp_error 0.
//  req_hold = req_dv & (state != DONE). Combinational; no request accepted outside IDLE.
//  FSM: IDLE -> WR (req_dv & req_write) | RD (req_dv & !req_write); all fields captured in flops.
//   WR: AWVALID and WVALID asserted next cycle, independently; each drops after its own handshake.
//       Move to WR_RESP once both AW and W have handshaken (any order, same cycle allowed).
//   WR_RESP: BREADY=1; on BVALID capture error = BRESP[1]; go to DONE.
//   RD: ARVALID until ARREADY; go to RD_RESP. RD_RESP: RREADY=1; on RVALID capture RDATA,
//       error = RRESP[1]; go to DONE.
//   DONE: one cycle, req_hold=0 (response delivered); -> IDLE. New request accepted the cycle after.
//  AxLEN=0, AxBURST=INCR, WLAST=1, AxSIZE fixed from DW. AxPROT=0, AxCACHE=0, AxLOCK=0.
//  Minimum latency (ready tied high): dv at cycle 0, AW/W handshake at 1, B at 2, hold low at 3.
//  Valid outputs never drop before handshake (AXI stability rule). Unused BID/RID ignored.
//  Reset mid-transaction: FSM returns to IDLE; the outstanding AXI transaction is abandoned.
//  The system resets the downstream fabric on the same reset.
// CONFIGURATION
//  MCI_AXI_MGR_TIMEOUT_EN defined: counter runs in WR_RESP/RD_RESP. It clears on state entry.
//   At TIMEOUT_CYCLES it forces DONE with resp_error=1 and resp_rdata=0.
//   It then enters DRAIN, holding BREADY or RREADY high until the late response arrives.
//   DRAIN discards that response and returns to IDLE; req_hold stays high for new requests.
//  Not defined: no counter, no DRAIN state; manager waits indefinitely for B/R.
// STRUCTURE
//  mci_axi_mgr_pkg: state enum (IDLE,WR,WR_RESP,RD,RD_RESP,DONE,DRAIN), AXI_RESP_* constants.
//  Single flat module; no sub-module (request capture and FSM are too small to split).
// TESTING
//  1 Write 0x1000, data 0xA5A5_5A5A, strb 0xF, all readies high: AW/W at cycle 1, B OKAY.
//    Expect hold low at cycle 3 with error=0.
//  2 Read 0x2004, RDATA=0xDEAD_BEEF, RRESP=OKAY after 5 wait cycles.
//    Expect resp_rdata=0xDEADBEEF, error=0, ARVALID held through stall.
//  3 Write with AWREADY delayed 3 cycles and WREADY immediate.
//    Expect WVALID to drop after 1 cycle, AWVALID held 4 cycles, single B accepted.
//  4 Read returning RRESP=SLVERR (2'b10), then write returning DECERR.
//    Expect resp_error=1 on both; back-to-back requests spaced by the DONE->IDLE cycle.
//  5 Assert rst during RD_RESP. Expect ARVALID/RREADY=0 and req_hold=0 immediately (async).
//    A following write completes normally.
//  6 (TIMEOUT_EN, TIMEOUT_CYCLES=16) BVALID withheld 40 cycles.
//    Expect error at cycle 16 of WR_RESP; new dv stalls until late B drained; next request ok.

Source files
------------

// File: rtl/mci_axi_mgr_pkg.sv
// mci_axi_mgr_pkg
//  Shared types and constants for the MCI single-outstanding AXI4 manager.
//  Contents:
//   mgr_state_e     manager FSM states
//   AXI_RESP_*      AXI response encodings
//   AXI_BURST_INCR  burst encoding used for every request
//   resp_is_error   maps an xRESP field onto the requester error flag
package mci_axi_mgr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_RESP,
    DONE,
    DRAIN
  } mgr_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/mci_axi_mgr.sv
// mci_axi_mgr
//  Single-outstanding AXI4 manager for MCI. Takes one simplex request at a
//  time from an internal initiator (req_dv held until req_hold drops) and
//  turns it into a single-beat AXI read or write on the outbound port. Read
//  data and an error flag are returned to the requester in the DONE cycle.
//
//  Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_dv / req_hold        request valid / stall back to the requester
//   req_write                1 = write, 0 = read
//   req_addr/wdata/wstrb     request address, write data, byte strobes
//   req_user / req_id        driven onto AxUSER / AxID
//   resp_rdata / resp_error  response, valid while req_dv & !req_hold
//   m_axi_aw*/w*/b*/ar*/r*   AXI4 manager channels
//
//  Configuration:
//   MCI_AXI_MGR_TIMEOUT_EN  when defined, a watchdog of TIMEOUT_CYCLES runs
//                           while waiting for B/R; on expiry the request is
//                           completed with an error and the late response is
//                           drained in the DRAIN state before the next request.
module mci_axi_mgr
  import mci_axi_mgr_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_USER_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        req_dv,
  input  logic                        req_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
  input  logic [AXI_USER_WIDTH-1:0]   req_user,
  input  logic [AXI_ID_WIDTH-1:0]     req_id,
  output logic                        req_hold,
  output logic [AXI_DATA_WIDTH-1:0]   resp_rdata,
  output logic                        resp_error,

  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_USER_WIDTH-1:0]   m_axi_awuser,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awcache,
  output logic                        m_axi_awlock,

  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,

  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,

  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [AXI_USER_WIDTH-1:0]   m_axi_aruser,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic [2:0]                  m_axi_arprot,
  output logic [3:0]                  m_axi_arcache,
  output logic                        m_axi_arlock,

  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid
);

  localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

  mgr_state_e state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [AXI_USER_WIDTH-1:0]   user_q;
  logic [AXI_ID_WIDTH-1:0]     id_q;
  logic                        aw_done_q;
  logic                        w_done_q;

  logic accept;
  logic timeout_hit;
  logic unused_ids;

  // Only one request is ever in flight, so a request is taken only in IDLE.
  assign accept   = (state_q == IDLE) && req_dv;
  assign req_hold = req_dv && (state_q != DONE);

  // Responses carry no routing information for a single-outstanding manager.
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  // Address/data channel payloads come straight from the captured request;
  // every transfer is a single INCR beat of the full bus width.
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = id_q;
  assign m_axi_awuser  = user_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awlock  = 1'b0;

  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = id_q;
  assign m_axi_aruser  = user_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arlock  = 1'b0;

`ifdef MCI_AXI_MGR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timed_out_q;
  logic            drain_write_q;

  // Expiry only counts when the response has not turned up in that very
  // cycle, so a response on the last allowed cycle still completes cleanly.
  assign timeout_hit = ((state_q == WR_RESP && !m_axi_bvalid) ||
                        (state_q == RD_RESP && !m_axi_rvalid)) &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles spent waiting in a response state (zero on
  // entry) and remembers whether the current request expired, plus its
  // direction so DRAIN knows which response channel to sink.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q      <= '0;
      timed_out_q   <= 1'b0;
      drain_write_q <= 1'b0;
    end else begin
      if (state_q == WR_RESP || state_q == RD_RESP) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end else begin
        to_cnt_q <= '0;
      end
      if (accept) begin
        timed_out_q   <= 1'b0;
        drain_write_q <= req_write;
      end else if (timeout_hit) begin
        timed_out_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  // FSM next-state and channel handshake outputs. In WR the AW and W
  // channels run independently; each valid drops once its own handshake
  // has happened, and the write moves on when both are done.
  always_comb begin
    state_d       = state_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_dv) begin
          state_d = req_write ? WR : RD;
        end
      end
      WR: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
        if ((aw_done_q || m_axi_awready) && (w_done_q || m_axi_wready)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid || timeout_hit) begin
          state_d = DONE;
        end
      end
      RD: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef MCI_AXI_MGR_TIMEOUT_EN
        state_d = timed_out_q ? DRAIN : IDLE;
`else
        state_d = IDLE;
`endif
      end
      DRAIN: begin
`ifdef MCI_AXI_MGR_TIMEOUT_EN
        m_axi_bready = drain_write_q;
        m_axi_rready = !drain_write_q;
        if ((drain_write_q && m_axi_bvalid) || (!drain_write_q && m_axi_rvalid)) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, request capture, per-channel handshake tracking and
  // the response registers returned to the requester. The response is
  // cleared when a request is accepted so a stale result never leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      user_q     <= '0;
      id_q       <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        wstrb_q    <= req_wstrb;
        user_q     <= req_user;
        id_q       <= req_id;
        aw_done_q  <= 1'b0;
        w_done_q   <= 1'b0;
        resp_rdata <= '0;
        resp_error <= 1'b0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) begin
          aw_done_q <= 1'b1;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          w_done_q <= 1'b1;
        end
        if (state_q == WR_RESP && m_axi_bvalid) begin
          resp_error <= resp_is_error(m_axi_bresp);
        end else if (state_q == RD_RESP && m_axi_rvalid) begin
          resp_rdata <= m_axi_rdata;
          resp_error <= resp_is_error(m_axi_rresp);
        end else if (timeout_hit) begin
          resp_rdata <= '0;
          resp_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mci_axi_mgr.sv
// tb_mci_axi_mgr
//  Self-checking bench for mci_axi_mgr. A table of directed transactions and
//  a batch of random ones are played through a cycle-driven AXI subordinate;
//  expected latency, error and read data come from a transaction-level model
//  of the manager's timing rules. Hand-written sequences cover asynchronous
//  reset mid-read and, with MCI_AXI_MGR_TIMEOUT_EN, the watchdog/drain path.
module tb_mci_axi_mgr;
  import mci_axi_mgr_pkg::*;

  localparam int TB_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_dv, req_write, req_hold, resp_error;
  logic [31:0] req_addr, req_wdata, req_user, resp_rdata;
  logic [3:0]  req_wstrb;
  logic [7:0]  req_id;

  logic        m_axi_awvalid, m_axi_awready, m_axi_awlock;
  logic [31:0] m_axi_awaddr, m_axi_awuser;
  logic [7:0]  m_axi_awid, m_axi_awlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst;
  logic [3:0]  m_axi_awcache;
  logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic [7:0]  m_axi_bid;
  logic        m_axi_arvalid, m_axi_arready, m_axi_arlock;
  logic [31:0] m_axi_araddr, m_axi_aruser;
  logic [7:0]  m_axi_arid, m_axi_arlen;
  logic [2:0]  m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic [7:0]  m_axi_rid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] user;
    logic [7:0]  id;
    int          a_delay;
    int          w_delay;
    int          r_delay;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_latency;
    logic        exp_error;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  mci_axi_mgr #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .AXI_USER_WIDTH(32),
    .AXI_ID_WIDTH(8),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_dv(req_dv), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_user(req_user),
    .req_id(req_id), .req_hold(req_hold), .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid),
    .m_axi_awuser(m_axi_awuser), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awprot(m_axi_awprot), .m_axi_awcache(m_axi_awcache),
    .m_axi_awlock(m_axi_awlock),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid),
    .m_axi_aruser(m_axi_aruser), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arprot(m_axi_arprot), .m_axi_arcache(m_axi_arcache),
    .m_axi_arlock(m_axi_arlock),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rid(m_axi_rid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic vec_t mkVec(input logic write, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input int a_d, input int w_d, input int r_d,
                                 input logic [1:0] resp, input logic [31:0] rdata,
                                 input int lat, input logic err, input logic [31:0] exp_rd);
    vec_t v;
    v.write = write;   v.addr = addr;   v.wdata = wdata; v.wstrb = wstrb;
    v.user  = ~addr;   v.id = addr[7:0] ^ 8'h3C;
    v.a_delay = a_d;   v.w_delay = w_d; v.r_delay = r_d;
    v.resp  = resp;    v.rdata = rdata;
    v.exp_latency = lat; v.exp_error = err; v.exp_rdata = exp_rd;
    return v;
  endfunction

  // Transaction-level model: request seen at cycle 0, address/data go out at
  // cycle 1 and complete after the subordinate's ready delay; the response
  // is offered r_delay cycles after the last handshake's following cycle and
  // the requester sees completion one cycle after the response handshake.
  function automatic vec_t modelFill(input vec_t v);
    int last_hs;
    last_hs = v.write ? (max2(v.a_delay, v.w_delay) + 1) : (v.a_delay + 1);
    v.exp_latency = last_hs + 1 + v.r_delay + 1;
    v.exp_error   = (v.resp == AXI_RESP_SLVERR) || (v.resp == AXI_RESP_DECERR);
    v.exp_rdata   = v.write ? 32'h0 : v.rdata;
    return v;
  endfunction

  // Plays one request against a cycle-driven subordinate and compares the
  // observed behaviour with the vector's expectations.
  task automatic applyStimulus(input vec_t v, input string tag);
    int t, done_t, exp_hs, awv_cnt, wv_cnt, arv_cnt;
    bit done, b_taken, r_taken;
    logic err_s;
    logic [31:0] rdata_s;
    logic [127:0] aw_f, w_f, ar_f;
    t = 0; done_t = -1; done = 0; b_taken = 0; r_taken = 0;
    awv_cnt = 0; wv_cnt = 0; arv_cnt = 0;
    err_s = 1'bx; rdata_s = 'x; aw_f = '0; w_f = '0; ar_f = '0;
    exp_hs = v.write ? (max2(v.a_delay, v.w_delay) + 1) : (v.a_delay + 1);
    req_dv = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
    req_wstrb = v.wstrb; req_user = v.user; req_id = v.id;
    m_axi_bresp = v.resp; m_axi_rresp = v.resp; m_axi_rdata = v.rdata;
    while (!done && t < 200) begin
      m_axi_awready = (t >= 1 + v.a_delay);
      m_axi_wready  = (t >= 1 + v.w_delay);
      m_axi_arready = (t >= 1 + v.a_delay);
      m_axi_bvalid  = v.write && !b_taken && (t >= exp_hs + 1 + v.r_delay);
      m_axi_rvalid  = !v.write && !r_taken && (t >= exp_hs + 1 + v.r_delay);
      @(negedge clk);
      if (m_axi_awvalid) awv_cnt++;
      if (m_axi_wvalid) wv_cnt++;
      if (m_axi_arvalid) arv_cnt++;
      if (m_axi_awvalid && m_axi_awready)
        aw_f = {m_axi_awaddr, m_axi_awid, m_axi_awuser, m_axi_awlen, m_axi_awsize,
                m_axi_awburst, m_axi_awprot, m_axi_awcache, m_axi_awlock};
      if (m_axi_wvalid && m_axi_wready) w_f = {m_axi_wdata, m_axi_wstrb, m_axi_wlast};
      if (m_axi_arvalid && m_axi_arready)
        ar_f = {m_axi_araddr, m_axi_arid, m_axi_aruser, m_axi_arlen, m_axi_arsize,
                m_axi_arburst, m_axi_arprot, m_axi_arcache, m_axi_arlock};
      if (m_axi_bvalid && m_axi_bready) b_taken = 1;
      if (m_axi_rvalid && m_axi_rready) r_taken = 1;
      if (!req_hold) begin
        done = 1; done_t = t; err_s = resp_error; rdata_s = resp_rdata;
      end
      @(posedge clk); #1;
      t++;
    end
    req_dv = 1'b0; m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    checkOutput({tag, "_latency"}, done_t, v.exp_latency);
    checkOutput({tag, "_error"}, err_s, v.exp_error);
    if (v.write) begin
      checkOutput({tag, "_awvalid_cycles"}, awv_cnt, v.a_delay + 1);
      checkOutput({tag, "_wvalid_cycles"}, wv_cnt, v.w_delay + 1);
      checkOutput({tag, "_arvalid_cycles"}, arv_cnt, 0);
      checkOutput({tag, "_aw_fields"}, aw_f,
                  {v.addr, v.id, v.user, 8'd0, 3'd2, AXI_BURST_INCR, 3'd0, 4'd0, 1'b0});
      checkOutput({tag, "_w_fields"}, w_f, {v.wdata, v.wstrb, 1'b1});
    end else begin
      checkOutput({tag, "_rdata"}, rdata_s, v.exp_rdata);
      checkOutput({tag, "_arvalid_cycles"}, arv_cnt, v.a_delay + 1);
      checkOutput({tag, "_awvalid_cycles"}, awv_cnt + wv_cnt, 0);
      checkOutput({tag, "_ar_fields"}, ar_f,
                  {v.addr, v.id, v.user, 8'd0, 3'd2, AXI_BURST_INCR, 3'd0, 4'd0, 1'b0});
    end
  endtask

  initial begin
    vec_t v;
    bit   seen;
    rst = 1'b1; req_dv = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    req_wstrb = 0; req_user = 0; req_id = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = AXI_RESP_OKAY; m_axi_bid = 8'h11;
    m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = AXI_RESP_OKAY; m_axi_rid = 8'h22;

    // Directed vectors with hand-derived expectations.
    vecs[0] = mkVec(1, 32'h0000_1000, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, AXI_RESP_OKAY,
                    32'h0, 3, 0, 32'h0);
    vecs[1] = mkVec(0, 32'h0000_2004, 32'h0, 4'h0, 5, 0, 0, AXI_RESP_OKAY,
                    32'hDEAD_BEEF, 8, 0, 32'hDEAD_BEEF);
    vecs[2] = mkVec(1, 32'h0000_3008, 32'h1234_5678, 4'h3, 3, 0, 0, AXI_RESP_OKAY,
                    32'h0, 6, 0, 32'h0);
    vecs[3] = mkVec(0, 32'h0000_400C, 32'h0, 4'h0, 0, 0, 0, AXI_RESP_SLVERR,
                    32'h0BAD_0BAD, 3, 1, 32'h0BAD_0BAD);
    vecs[4] = mkVec(1, 32'h0000_5010, 32'hCAFE_F00D, 4'hC, 0, 0, 0, AXI_RESP_DECERR,
                    32'h0, 3, 1, 32'h0);
    vecs[5] = mkVec(1, 32'h0000_6014, 32'h0F0F_F0F0, 4'h5, 0, 2, 1, AXI_RESP_EXOKAY,
                    32'h0, 6, 0, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
    checkOutput("reset_readies", {m_axi_bready, m_axi_rready}, 2'b00);
    checkOutput("reset_resp", {resp_rdata, resp_error}, 33'h0);
    checkOutput("reset_hold", req_hold, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      v = mkVec(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                2'($urandom_range(0, 3)), $urandom, 0, 0, 32'h0);
      v = modelFill(v);
      applyStimulus(v, $sformatf("rand%0d", i));
    end

    // Reset while waiting for read data, then a normal write.
    req_dv = 1'b1; req_write = 1'b0; req_addr = 32'h0000_7000;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (m_axi_rready) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("rst_reached_rd_resp", seen, 1'b1);
    #2;
    rst = 1'b1; req_dv = 1'b0; m_axi_arready = 1'b0;
    #1;
    checkOutput("rst_async_arvalid_rready", {m_axi_arvalid, m_axi_rready}, 2'b00);
    checkOutput("rst_async_hold", req_hold, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(vecs[0], "post_reset_write");

`ifdef MCI_AXI_MGR_TIMEOUT_EN
    begin
      int  done2_t, stall_bad;
      bit  late_taken, new_taken, fin;
      done2_t = -1; stall_bad = 0; late_taken = 0; new_taken = 0; fin = 0;
      req_dv = 1'b1; req_write = 1'b1; req_addr = 32'h0000_8000;
      req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      for (int t = 0; t < 80 && !fin; t++) begin
        m_axi_bvalid = (!late_taken && t >= 42) || (late_taken && !new_taken && t >= 45);
        m_axi_bresp  = late_taken ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        @(negedge clk);
        if (t == 18) begin
          checkOutput("to_hold_low", req_hold, 1'b0);
          checkOutput("to_error", resp_error, 1'b1);
          checkOutput("to_rdata", resp_rdata, 32'h0);
        end
        if (t >= 19 && t <= 42 && (m_axi_awvalid || !req_hold)) stall_bad++;
        if (m_axi_bvalid && m_axi_bready) begin
          if (late_taken) new_taken = 1;
          else late_taken = 1;
        end
        if (t >= 19 && !req_hold) begin
          done2_t = t;
          checkOutput("to_next_error", resp_error, 1'b0);
          fin = 1;
        end
        @(posedge clk); #1;
        if (t == 18) begin
          req_addr = 32'h0000_8004; req_wdata = 32'h0123_4567;
        end
      end
      req_dv = 1'b0; m_axi_bvalid = 1'b0;
      checkOutput("to_stall_during_drain", stall_bad, 0);
      checkOutput("to_next_latency", done2_t, 46);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
